// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier job controller.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam int unsigned MCAND_W_DEF    = 8;
  localparam int unsigned MPLR_W_DEF     = 4;
  localparam int unsigned PROD_W_DEF     = 8;
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned CNT_W          = 8;

endpackage

// File: rtl/booth_job_ctrl_if.sv
// Operand-in / result-out valid/ready handshakes of booth_job_ctrl.
interface booth_job_ctrl_if #(
  parameter int unsigned MCAND_W = booth_pkg::MCAND_W_DEF,
  parameter int unsigned MPLR_W  = booth_pkg::MPLR_W_DEF,
  parameter int unsigned PROD_W  = booth_pkg::PROD_W_DEF
);
  logic               in_valid;
  logic               in_ready;
  logic [MCAND_W-1:0] in_multiplicand;
  logic [MPLR_W-1:0]  in_multiplier;
  logic               out_valid;
  logic               out_ready;
  logic [PROD_W-1:0]  out_product;
  logic               out_cout;

  modport master (
    output in_valid, in_multiplicand, in_multiplier, out_ready,
    input  in_ready, out_valid, out_product, out_cout
  );

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, out_ready,
    output in_ready, out_valid, out_product, out_cout
  );
endinterface

// File: rtl/booth_cycle_cnt.sv
// Loadable down-counter with enable and zero flag, times the RUN phase.
module booth_cycle_cnt
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/booth_job_ctrl.sv
// Job controller wrapped around the 8x4 Booth multiplier: launch, time, collect.
// Optional BOOTH_JOB_CTRL_CNT_EN adds a 16-bit completed-job counter port.
module booth_job_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned MCAND_W    = MCAND_W_DEF,
  parameter int unsigned MPLR_W     = MPLR_W_DEF,
  parameter int unsigned PROD_W     = PROD_W_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  booth_job_ctrl_if.slave    bus,
  output logic               mul_rst,
  output logic [MCAND_W-1:0] mul_multiplicand,
  output logic [MPLR_W-1:0]  mul_multiplier,
  input  logic [PROD_W-1:0]  mul_product,
  input  logic               mul_cout
`ifdef BOOTH_JOB_CTRL_CNT_EN
  ,
  output logic [15:0]        jobs_done
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t           state, next_state;
  logic             accept, cnt_load, cnt_en, cnt_zero, capture;
  logic [CNT_W-1:0] cnt;

  booth_cycle_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CNT_LOAD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.in_valid) next_state = LOAD;
      LOAD: next_state = RUN;
      RUN:  if (cnt_zero) next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    accept        = bus.in_valid && (state == IDLE);
    cnt_load      = (state == LOAD);
    cnt_en        = (state == RUN) && !cnt_zero;
    capture       = (state == RUN) && cnt_zero;
  end

  // Registered from next_state so the multiplier reset is glitch-free and
  // low exactly for the LOAD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mul_rst <= 1'b0;
    else
      mul_rst <= (next_state != LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else if (accept) begin
      mul_multiplicand <= bus.in_multiplicand;
      mul_multiplier   <= bus.in_multiplier;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_product <= '0;
      bus.out_cout    <= 1'b0;
    end else if (capture) begin
      bus.out_product <= mul_product;
      bus.out_cout    <= mul_cout;
    end
  end

`ifdef BOOTH_JOB_CTRL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      jobs_done <= '0;
    else if (bus.out_valid && bus.out_ready)
      jobs_done <= jobs_done + 16'd1;
  end
`endif

endmodule
